// File: rtl/sb_rx_pkg.sv
// Shared types and widths for the sideband RX message queue.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sb_rx_pkg;

    localparam int MSG_NO_W   = 4;
    localparam int MSG_INFO_W = 3;
    localparam int DATA_W     = 16;
    localparam int ENTRY_W    = MSG_NO_W + MSG_INFO_W + DATA_W;

    // One queued sideband message (23 bits).
    typedef struct packed {
        logic [MSG_NO_W-1:0]   msg_no;
        logic [MSG_INFO_W-1:0] msg_info;
        logic [DATA_W-1:0]     data;
    } entry_t;

    // Occupancy state of the queue.
    typedef enum logic [1:0] {
        Q_EMPTY   = 2'd0,
        Q_PARTIAL = 2'd1,
        Q_FULL    = 2'd2
    } q_state_e;

endpackage

// File: rtl/sb_rx_msg_mem.sv
// Message storage: DEPTH x entry register array, no reset on contents.
// Latency: write lands at the clock edge; read is combinational from rd_addr.
// Backpressure: none; the owner decides when wr_en is legal.
//
// Ports:
//   i_clk            clock
//   wr_en/wr_addr    write strobe and slot index
//   wr_dat           entry to store
//   rd_addr/rd_dat   asynchronous read port (queue head)
module sb_rx_msg_mem
    import sb_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [ENTRY_W-1:0]       wr_dat,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [ENTRY_W-1:0]       rd_dat
);

    entry_t mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= entry_t'(wr_dat);
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/sb_rx_msg_queue.sv
// FWFT queue of decoded sideband RX messages, flushed on any LTSM state change.
// Latency: one cycle from accepted push to o_msg_valid; head read straight from storage.
// Backpressure: none upstream; pushes while full (and no pop) are dropped and flagged.
//
// Ports:
//   i_clk, i_rst_n                  clock, synchronous active-low reset
//   i_msg_valid/no/info/data        decoded message pulse and fields
//   i_parity_error                  qualifies i_msg_valid: drop and count
//   i_state                         LTSM state; any change flushes the queue
//   i_ltsm_ready                    consumer pops the head entry
//   o_msg_valid/no/info/data        head entry
//   o_count, o_full, o_empty        occupancy
//   o_overflow                      sticky drop-on-full flag (cleared by flush)
//   o_parity_drop_cnt               saturating parity-drop counter (reset only)
module sb_rx_msg_queue
    import sb_rx_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_msg_valid,
    input  logic [3:0]              i_msg_no,
    input  logic [2:0]              i_msg_info,
    input  logic [15:0]             i_data,
    input  logic                    i_parity_error,
    input  logic [3:0]              i_state,
    input  logic                    i_ltsm_ready,
    output logic                    o_msg_valid,
    output logic [3:0]              o_msg_no,
    output logic [2:0]              o_msg_info,
    output logic [15:0]             o_data,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_overflow,
    output logic [ERR_CNT_W-1:0]    o_parity_drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0]     PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE   = ERR_CNT_W'(1);

    logic [3:0]           state_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_nxt;
    q_state_e             q_state_q;
    q_state_e             q_state_nxt;
    logic                 overflow_q;
    logic [ERR_CNT_W-1:0] perr_cnt_q;

    logic   flush;
    logic   msg_ok;
    logic   pop;
    logic   push;
    entry_t wr_entry;
    entry_t head;

    // ------------------------------------------------------------------
    // Push/pop qualification
    // ------------------------------------------------------------------
    always_comb begin
        flush  = (i_state != state_q);
        msg_ok = i_msg_valid && !i_parity_error;
        // A flush discards the queue, so any pop that cycle is meaningless.
        pop    = o_msg_valid && i_ltsm_ready && !flush;
        // On flush the queue is about to be empty, so the push always fits;
        // when full, a same-cycle pop frees the slot.
        push   = msg_ok && (flush || (q_state_q != Q_FULL) || pop);
    end

    always_comb begin
        count_nxt = count_q;
        if (flush) begin
            count_nxt = push ? CNT_ONE : '0;
        end else if (push && !pop) begin
            count_nxt = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_nxt = count_q - CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy FSM: drives the flags, tracks count_nxt
    // ------------------------------------------------------------------
    always_comb begin
        q_state_nxt = q_state_q;
        case (q_state_q)
            Q_EMPTY: begin
                // Only a push leaves EMPTY; DEPTH >= 2 so one entry is PARTIAL.
                if (push) begin
                    q_state_nxt = Q_PARTIAL;
                end
            end
            Q_PARTIAL: begin
                if (count_nxt == '0) begin
                    q_state_nxt = Q_EMPTY;
                end else if (count_nxt == CNT_DEPTH) begin
                    q_state_nxt = Q_FULL;
                end
            end
            Q_FULL: begin
                if (flush) begin
                    q_state_nxt = push ? Q_PARTIAL : Q_EMPTY;
                end else if (pop && !push) begin
                    q_state_nxt = Q_PARTIAL;
                end
            end
            default: begin
                q_state_nxt = Q_EMPTY;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            q_state_q <= Q_EMPTY;
        end else begin
            q_state_q <= q_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, count, sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            perr_cnt_q <= '0;
        end else begin
            state_q <= i_state;
            count_q <= count_nxt;

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end

            // Flushing snaps the read pointer onto the write pointer, so a
            // push written at wr_ptr_q this cycle becomes the lone entry.
            if (flush) begin
                rd_ptr_q <= wr_ptr_q;
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end

            if (flush) begin
                overflow_q <= 1'b0;
            end else if (msg_ok && (q_state_q == Q_FULL) && !pop) begin
                overflow_q <= 1'b1;
            end

            // Not touched by flush: this is a link-health statistic.
            if (i_msg_valid && i_parity_error && !(&perr_cnt_q)) begin
                perr_cnt_q <= perr_cnt_q + ERR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    assign wr_entry = '{msg_no: i_msg_no, msg_info: i_msg_info, data: i_data};

    sb_rx_msg_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_dat  (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_dat  (head)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_empty           = (q_state_q == Q_EMPTY);
    assign o_full            = (q_state_q == Q_FULL);
    assign o_msg_valid       = !o_empty;
    assign o_msg_no          = head.msg_no;
    assign o_msg_info        = head.msg_info;
    assign o_data            = head.data;
    assign o_count           = count_q;
    assign o_overflow        = overflow_q;
    assign o_parity_drop_cnt = perr_cnt_q;

endmodule

// File: tb/tb_sb_rx_msg_queue.sv
// Self-checking bench for sb_rx_msg_queue: queue-based reference model checked
// every cycle, plus directed literal expectations for the key scenarios.
module tb_sb_rx_msg_queue;

    localparam int DEPTH     = 4;
    localparam int ERR_CNT_W = 8;

    logic        clk;
    logic        rst_n;
    logic        msg_valid;
    logic [3:0]  msg_no;
    logic [2:0]  msg_info;
    logic [15:0] data;
    logic        parity_error;
    logic [3:0]  state;
    logic        ltsm_ready;
    logic        o_msg_valid;
    logic [3:0]  o_msg_no;
    logic [2:0]  o_msg_info;
    logic [15:0] o_data;
    logic [2:0]  o_count;
    logic        o_full;
    logic        o_empty;
    logic        o_overflow;
    logic [7:0]  o_parity_drop_cnt;

    sb_rx_msg_queue #(
        .DEPTH     (DEPTH),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_msg_valid       (msg_valid),
        .i_msg_no          (msg_no),
        .i_msg_info        (msg_info),
        .i_data            (data),
        .i_parity_error    (parity_error),
        .i_state           (state),
        .i_ltsm_ready      (ltsm_ready),
        .o_msg_valid       (o_msg_valid),
        .o_msg_no          (o_msg_no),
        .o_msg_info        (o_msg_info),
        .o_data            (o_data),
        .o_count           (o_count),
        .o_full            (o_full),
        .o_empty           (o_empty),
        .o_overflow        (o_overflow),
        .o_parity_drop_cnt (o_parity_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a plain queue of messages
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]  no;
        logic [2:0]  info;
        logic [15:0] data;
    } m_t;

    m_t         mq[$];
    bit         m_ovf;
    int         m_pcnt;
    logic [3:0] m_state;

    always @(posedge clk) begin
        m_t e;
        if (!rst_n) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_pcnt  = 0;
            m_state = 4'h0;
        end else begin
            e.no   = msg_no;
            e.info = msg_info;
            e.data = data;
            if (msg_valid && parity_error && m_pcnt < 255) m_pcnt++;
            if (state != m_state) begin
                mq.delete();
                m_ovf = 1'b0;
                if (msg_valid && !parity_error) mq.push_back(e);
            end else begin
                if (ltsm_ready && mq.size() > 0) void'(mq.pop_front());
                if (msg_valid && !parity_error) begin
                    if (mq.size() < DEPTH) mq.push_back(e);
                    else m_ovf = 1'b1;
                end
            end
            m_state = state;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_count", 32'(o_count), 32'(mq.size()));
            chk("m_empty", 32'(o_empty), 32'(mq.size() == 0));
            chk("m_full", 32'(o_full), 32'(mq.size() == DEPTH));
            chk("m_valid", 32'(o_msg_valid), 32'(mq.size() != 0));
            chk("m_overflow", 32'(o_overflow), 32'(m_ovf));
            chk("m_pcnt", 32'(o_parity_drop_cnt), 32'(m_pcnt));
            if (mq.size() > 0) begin
                chk("m_head_no", 32'(o_msg_no), 32'(mq[0].no));
                chk("m_head_info", 32'(o_msg_info), 32'(mq[0].info));
                chk("m_head_data", 32'(o_data), 32'(mq[0].data));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: set inputs, clock once, return 1 time unit after edge
    // ------------------------------------------------------------------
    task automatic cyc(input bit v, input logic [3:0] no, input logic [15:0] d,
                       input bit perr, input bit rdy);
        msg_valid    = v;
        msg_no       = no;
        msg_info     = no[2:0];
        data         = d;
        parity_error = perr;
        ltsm_ready   = rdy;
        @(posedge clk);
        #1;
        msg_valid    = 1'b0;
        parity_error = 1'b0;
        ltsm_ready   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        msg_valid    = 1'b0;
        msg_no       = 4'h0;
        msg_info     = 3'h0;
        data         = 16'h0;
        parity_error = 1'b0;
        state        = 4'h0;
        ltsm_ready   = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(1);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_valid", 32'(o_msg_valid), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_pcnt", 32'(o_parity_drop_cnt), 32'd0);
        rst_n = 1'b1;

        // First push after release, ready low: visible one edge later, held
        cyc(1'b1, 4'h3, 16'hA5A5, 1'b0, 1'b0);
        chk("lat_valid", 32'(o_msg_valid), 32'd1);
        chk("lat_no", 32'(o_msg_no), 32'h3);
        chk("lat_data", 32'(o_data), 32'hA5A5);
        chk("lat_count", 32'(o_count), 32'd1);
        idle(2);
        chk("hold_data", 32'(o_data), 32'hA5A5);
        chk("hold_count", 32'(o_count), 32'd1);
        cyc(1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
        chk("pop_empty", 32'(o_empty), 32'd1);

        // Five pushes into a 4-deep queue: fifth is dropped
        for (int i = 1; i <= 5; i++) cyc(1'b1, 4'(i), 16'h1000 + 16'(i), 1'b0, 1'b0);
        chk("ovf_full", 32'(o_full), 32'd1);
        chk("ovf_count", 32'(o_count), 32'd4);
        chk("ovf_flag", 32'(o_overflow), 32'd1);
        chk("ovf_head", 32'(o_msg_no), 32'h1);
        chk("ovf_head_data", 32'(o_data), 32'h1001);
        // Drain: the model checks order 1..4, fifth never appears
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
        chk("drain_empty", 32'(o_empty), 32'd1);
        chk("drain_ovf_sticky", 32'(o_overflow), 32'd1);

        // State change with no push: clears overflow, queue stays empty
        state = 4'h1;
        idle(1);
        chk("flush_ovf_clr", 32'(o_overflow), 32'd0);

        // Fill, then push+pop together across pointer wrap
        for (int i = 6; i <= 9; i++) cyc(1'b1, 4'(i), 16'h2000 + 16'(i), 1'b0, 1'b0);
        cyc(1'b1, 4'hA, 16'h200A, 1'b0, 1'b1);
        chk("pp_head", 32'(o_msg_no), 32'h7);
        chk("pp_count", 32'(o_count), 32'd4);
        for (int i = 11; i <= 15; i++) cyc(1'b1, 4'(i), 16'h2000 + 16'(i), 1'b0, 1'b1);
        chk("wrap_head", 32'(o_msg_no), 32'hC);
        chk("wrap_count", 32'(o_count), 32'd4);
        chk("wrap_ovf", 32'(o_overflow), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
        chk("wrap_drain", 32'(o_empty), 32'd1);

        // Parity-failed messages: dropped, counter saturates
        for (int i = 0; i < 300; i++) cyc(1'b1, 4'(i), 16'(i), 1'b1, 1'b0);
        chk("perr_empty", 32'(o_empty), 32'd1);
        chk("perr_sat", 32'(o_parity_drop_cnt), 32'hFF);

        // Three entries queued, state change with simultaneous push
        state = 4'h2;
        idle(1);
        for (int i = 1; i <= 3; i++) cyc(1'b1, 4'(i), 16'h3000 + 16'(i), 1'b0, 1'b0);
        chk("pre_flush_count", 32'(o_count), 32'd3);
        state = 4'h5;
        cyc(1'b1, 4'h9, 16'h3009, 1'b0, 1'b1);
        chk("flush_count", 32'(o_count), 32'd1);
        chk("flush_head", 32'(o_msg_no), 32'h9);
        chk("flush_ovf", 32'(o_overflow), 32'd0);
        chk("flush_pcnt_kept", 32'(o_parity_drop_cnt), 32'hFF);

        // Mid-operation reset with two entries queued
        cyc(1'b1, 4'hA, 16'h300A, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(o_count), 32'd2);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("mrst_empty", 32'(o_empty), 32'd1);
        chk("mrst_count", 32'(o_count), 32'd0);
        chk("mrst_pcnt", 32'(o_parity_drop_cnt), 32'd0);
        cyc(1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
        chk("empty_pop_count", 32'(o_count), 32'd0);
        chk("empty_pop_empty", 32'(o_empty), 32'd1);
        cyc(1'b1, 4'h6, 16'h5A5A, 1'b0, 1'b0);
        chk("post_rst_lat", 32'(o_data), 32'h5A5A);
        chk("post_rst_count", 32'(o_count), 32'd1);
        idle(2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sb_rx_msg_queue.md
SB_RX_MSG_QUEUE -- requirements
Module: sb_rx_msg_queue

Interface
REQ-001 Parameter DEPTH, 4, number of message entries; power of two, 2..16.
REQ-002 Parameter ERR_CNT_W, 8, width of the parity-drop counter.
REQ-003 i_clk  input  1  sideband logic clock; single clock domain for the whole block.
REQ-004 i_rst_n  input  1  reset, synchronous and active-low.
REQ-005 i_msg_valid  input  1  single-cycle pulse from the sideband RX decode path: a decoded message is present.
REQ-006 i_msg_no  input  4  decoded message number.
REQ-007 i_msg_info  input  3  decoded message info.
REQ-008 i_data  input  16  decoded message data field.
REQ-009 i_parity_error  input  1  qualifies i_msg_valid: the message failed parity.
REQ-010 i_state  input  4  current LTSM state encoding.
REQ-011 i_ltsm_ready  input  1  consumer accepts the head entry this cycle.
REQ-012 o_msg_valid  output  1  head entry present (not empty).
REQ-013 o_msg_no / o_msg_info / o_data  output  4/3/16  head entry fields.
REQ-014 o_count  output  $clog2(DEPTH)+1  occupied entries.
REQ-015 o_full / o_empty  output  1/1  occupancy flags.
REQ-016 o_overflow  output  1  sticky: a valid message was dropped because the queue was full.
REQ-017 o_parity_drop_cnt  output  ERR_CNT_W  saturating count of parity-dropped messages.

Function
REQ-018 Queue SHALL be first-word-fall-through: head fields driven directly from storage at the read pointer; fields are don't-care while o_empty=1.
REQ-019 Push SHALL occur when i_msg_valid=1 and i_parity_error=0, and either not full or a pop happens in the same cycle.
REQ-020 Pop SHALL occur when o_msg_valid=1 and i_ltsm_ready=1; i_ltsm_ready while empty SHALL have no effect.
REQ-021 Push-to-output latency SHALL be one cycle: entry written at edge N, o_msg_valid=1 after edge N; no combinational bypass from input to output.
REQ-022 Simultaneous push and pop SHALL leave o_count unchanged; when full, the pop frees the slot and the push is accepted.
REQ-023 Push while full without a pop SHALL drop the message and set o_overflow; queue contents are unchanged.
REQ-024 i_msg_valid=1 with i_parity_error=1 SHALL drop the message and increment o_parity_drop_cnt, saturating at all-ones.
REQ-025 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; o_full = (o_count==DEPTH); o_empty = (o_count==0).
REQ-026 The block SHALL register i_state; a cycle where i_state differs from the registered value is a flush cycle.
REQ-027 Flush cycle: all entries discarded, o_overflow cleared, any pop ignored; a qualified push in the same cycle SHALL become the sole entry (o_count=1).
REQ-028 o_parity_drop_cnt SHALL NOT be cleared by flush, only by reset.
REQ-029 Queue SHALL hold per-state FSM: EMPTY, PARTIAL, FULL, derived from o_count, with transitions only on push/pop/flush as above.

Reset
REQ-030 While i_rst_n=0 at a rising i_clk edge: pointers=0, o_count=0, o_empty=1, o_full=0, o_msg_valid=0, o_overflow=0, o_parity_drop_cnt=0, registered state=0.
REQ-031 Storage array SHALL NOT require reset; reset mid-operation discards all entries, and the first push after release follows REQ-021.

Structure
REQ-032 Package sb_rx_pkg SHALL hold the entry struct typedef (msg_no, msg_info, data; 23 bits) and width constants MSG_NO_W=4, MSG_INFO_W=3, DATA_W=16.
REQ-033 Storage SHALL be one sub-module sb_rx_msg_mem (DEPTH x entry, synchronous write, asynchronous read); pointers, count and flags stay in sb_rx_msg_queue.

Verification
REQ-034 Reset release, push msg_no=4'h3 data=16'hA5A5, ready=0 -> o_msg_valid=1 next cycle, o_data=16'hA5A5, o_count=1, held stable.
REQ-035 DEPTH=4: push 5 messages with ready=0 -> o_full=1, o_count=4, o_overflow=1, head = first message, fifth lost.
REQ-036 Full queue, push and ready in same cycle -> o_count stays 4, o_overflow stays 0, o_msg_no order preserved across pointer wrap.
REQ-037 300 pushes with i_parity_error=1 -> queue empty, o_parity_drop_cnt=8'hFF (saturated).
REQ-038 3 entries queued, i_state 4'h2->4'h5 with a simultaneous push of msg_no=4'h9 -> next cycle o_count=1, o_msg_no=4'h9, o_overflow=0.
REQ-039 i_rst_n=0 for one edge with 2 entries queued -> o_empty=1, o_count=0, counter=0; pop while empty -> no change.
